// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 slave giving an external master access to a
// bank of 16 x 32-bit registers (0..14 read/write, 15 = read-only ID).
// Every SPI input is resynchronised into CLK_I, so the SPI clock must run
// at no more than CLK_I/8. A frame is an 8-bit command (bit7 = read,
// bits 6:4 must be zero, bits 3:0 = address) followed by 32 data bits,
// with both command and data sent MSB first.
// Ports:
//   CLK_I, RST_I             system clock, synchronous active-high reset
//   SPI_CLK/CS_N/MOSI        SPI bus inputs, asynchronous to CLK_I
//   SPI_MISO, SPI_MISO_OE    read data and its output enable
//   REG_ADR_I, REG_DAT_O     local combinational read port
//   WR_STB, WR_ADR, WR_DAT   committed-write pulse with its address/data
//   FRAME_ERR                one-cycle pulse on an aborted or invalid frame
`timescale 1ns/1ps
module spi_slave_regs #(
  parameter int          SYNC_STAGES = 2,             // must be >= 2
  parameter logic [31:0] ID_VALUE    = 32'h5A5A_0001
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        SPI_CLK,
  input  logic        SPI_CS_N,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  output logic        SPI_MISO_OE,
  input  logic [3:0]  REG_ADR_I,
  output logic [31:0] REG_DAT_O,
  output logic        WR_STB,
  output logic [3:0]  WR_ADR,
  output logic [31:0] WR_DAT,
  output logic        FRAME_ERR
);

  typedef enum logic [2:0] {
    ST_WAIT = 3'd0, ST_IDLE = 3'd1, ST_CMD = 3'd2, ST_DATA = 3'd3, ST_DONE = 3'd4
  } state_t;

  state_t state_r, state_nxt_s;

  logic [SYNC_STAGES-1:0] sclk_sync_r, cs_sync_r, mosi_sync_r;
  logic [SYNC_STAGES:0]   settle_r;
  logic sclk_d_r, cs_d_r;
  logic sclk_s, cs_s, mosi_s, settled_s;
  logic sclk_rise_s, sclk_fall_s, cs_fall_s;

  logic [5:0]        cnt_r;
  logic [7:0]        cmd_r;
  logic [30:0]       rx_sr_r;
  logic [30:0]       tx_sr_r;
  logic [14:0][31:0] regs_r;
  logic              miso_r, miso_oe_r, wr_stb_r, frame_err_r;
  logic [3:0]        wr_adr_r;
  logic [31:0]       wr_dat_r;

  logic cnt_clr_s, cnt_inc_s, shift_cmd_s, shift_rx_s, load_tx_s, shift_tx_s;
  logic commit_s, frame_err_s, miso_oe_s;
  logic cmd_valid_s, cmd_rd_s;
  logic [31:0] rx_next_s, tx_load_s;

  // Register-bank read; address 15 returns the fixed ID.
  function automatic logic [31:0] reg_read(input logic [3:0] adr,
                                           input logic [14:0][31:0] regs);
    logic [31:0] val;
    val = ID_VALUE;
    for (int i = 0; i < 15; i++) begin
      val = (adr == 4'(i)) ? regs[i] : val;
    end
    return val;
  endfunction

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s        = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  // Right after reset the synchronisers still hold idle levels rather than
  // the bus; the settle chain keeps WAIT from trusting them too early.
  assign settled_s   = settle_r[SYNC_STAGES];
  assign sclk_rise_s = sclk_s & ~sclk_d_r;
  assign sclk_fall_s = ~sclk_s & sclk_d_r;
  assign cs_fall_s   = cs_d_r & ~cs_s;
  assign cmd_valid_s = (cmd_r[6:4] == 3'b000);
  assign cmd_rd_s    = cmd_r[7];
  assign rx_next_s   = {rx_sr_r, mosi_s};
  assign tx_load_s   = reg_read(cmd_r[3:0], regs_r);

  // Input synchronisers, edge-detect history and post-reset settle chain.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      settle_r    <= {(SYNC_STAGES+1){1'b0}};
      sclk_d_r    <= 1'b0;
      cs_d_r      <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SPI_CLK};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], SPI_CS_N};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], SPI_MOSI};
      settle_r    <= {settle_r[SYNC_STAGES-1:0], 1'b1};
      sclk_d_r    <= sclk_s;
      cs_d_r      <= cs_s;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_r <= ST_WAIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; CS_N high returns every active state to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_WAIT: begin
        if (settled_s && cs_s) state_nxt_s = ST_IDLE;
        else                   state_nxt_s = ST_WAIT;
      end
      ST_IDLE: begin
        if (cs_fall_s) state_nxt_s = ST_CMD;
        else           state_nxt_s = ST_IDLE;
      end
      ST_CMD: begin
        if (cs_s)                  state_nxt_s = ST_IDLE;
        else if (cnt_r == 6'd8)    state_nxt_s = cmd_valid_s ? ST_DATA : ST_DONE;
        else                       state_nxt_s = ST_CMD;
      end
      ST_DATA: begin
        if (cs_s)                                state_nxt_s = ST_IDLE;
        else if (sclk_rise_s && cnt_r == 6'd39)  state_nxt_s = ST_DONE;
        else                                     state_nxt_s = ST_DATA;
      end
      ST_DONE: begin
        if (cs_s) state_nxt_s = ST_IDLE;
        else      state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_WAIT;
    endcase
  end

  // FSM output decode: datapath controls and next values of the outputs.
  always_comb begin
    cnt_clr_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    shift_cmd_s = 1'b0;
    shift_rx_s  = 1'b0;
    load_tx_s   = 1'b0;
    shift_tx_s  = 1'b0;
    commit_s    = 1'b0;
    frame_err_s = 1'b0;
    miso_oe_s   = 1'b0;
    case (state_r)
      ST_IDLE: cnt_clr_s = 1'b1;
      ST_CMD: begin
        if (cs_s) begin
          frame_err_s = (cnt_r != 6'd0);
        end else if (cnt_r == 6'd8) begin
          // Command decode cycle, one cycle after the 8th rising edge.
          frame_err_s = ~cmd_valid_s;
          load_tx_s   = cmd_valid_s & cmd_rd_s;
          miso_oe_s   = cmd_valid_s & cmd_rd_s;
        end else begin
          shift_cmd_s = sclk_rise_s;
          cnt_inc_s   = sclk_rise_s;
        end
      end
      ST_DATA: begin
        if (cs_s) begin
          frame_err_s = 1'b1;
        end else if (sclk_rise_s) begin
          shift_rx_s = 1'b1;
          cnt_inc_s  = 1'b1;
          commit_s   = (cnt_r == 6'd39) & ~cmd_rd_s & (cmd_r[3:0] != 4'd15);
          miso_oe_s  = miso_oe_r & (cnt_r != 6'd39);
        end else begin
          // Bit 31 is already on MISO, so the fall after edge 8 must not shift.
          shift_tx_s = sclk_fall_s & miso_oe_r & (cnt_r >= 6'd9);
          miso_oe_s  = miso_oe_r;
        end
      end
      default: begin
        cnt_clr_s = 1'b0;
      end
    endcase
  end

  // Datapath: bit counter, shift registers, register bank and outputs.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      cnt_r       <= 6'd0;
      cmd_r       <= 8'd0;
      rx_sr_r     <= 31'd0;
      tx_sr_r     <= 31'd0;
      regs_r      <= {(15*32){1'b0}};
      miso_r      <= 1'b0;
      miso_oe_r   <= 1'b0;
      wr_stb_r    <= 1'b0;
      frame_err_r <= 1'b0;
      wr_adr_r    <= 4'd0;
      wr_dat_r    <= 32'd0;
    end else begin
      if (cnt_clr_s)      cnt_r <= 6'd0;
      else if (cnt_inc_s) cnt_r <= cnt_r + 6'd1;
      if (shift_cmd_s) cmd_r   <= {cmd_r[6:0], mosi_s};
      if (shift_rx_s)  rx_sr_r <= rx_next_s[30:0];
      if (load_tx_s) begin
        miso_r  <= tx_load_s[31];
        tx_sr_r <= tx_load_s[30:0];
      end else if (shift_tx_s) begin
        miso_r  <= tx_sr_r[30];
        tx_sr_r <= {tx_sr_r[29:0], 1'b0};
      end else if (!miso_oe_s) begin
        miso_r  <= 1'b0;
        tx_sr_r <= 31'd0;
      end
      miso_oe_r   <= miso_oe_s;
      frame_err_r <= frame_err_s;
      wr_stb_r    <= commit_s;
      if (commit_s) begin
        wr_adr_r <= cmd_r[3:0];
        wr_dat_r <= rx_next_s;
      end
      for (int i = 0; i < 15; i++) begin
        if (commit_s && cmd_r[3:0] == 4'(i)) regs_r[i] <= rx_next_s;
      end
    end
  end

  assign SPI_MISO    = miso_r;
  assign SPI_MISO_OE = miso_oe_r;
  assign WR_STB      = wr_stb_r;
  assign WR_ADR      = wr_adr_r;
  assign WR_DAT      = wr_dat_r;
  assign FRAME_ERR   = frame_err_r;
  assign REG_DAT_O   = reg_read(REG_ADR_I, regs_r);

endmodule

// File: doc/spi_slave_regs.md
SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2: number of CLK_I flip-flops synchronizing SPI_CLK, SPI_CS_N and SPI_MOSI (minimum 2).
REQ-002 The module SHALL have parameter ID_VALUE, default 32'h5A5A_0001: fixed contents of read-only register 15.
REQ-003 The module SHALL have port CLK_I, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-004 The module SHALL have port RST_I, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port SPI_CLK, input, 1 bit: serial clock from the SPI master (mode 0, CPOL=0, CPHA=0), asynchronous to CLK_I.
REQ-006 The module SHALL have port SPI_CS_N, input, 1 bit: chip select, active low, asynchronous.
REQ-007 The module SHALL have port SPI_MOSI, input, 1 bit: serial data from the master, MSB first.
REQ-008 The module SHALL have port SPI_MISO, output, 1 bit: serial data to the master, MSB first.
REQ-009 The module SHALL have port SPI_MISO_OE, output, 1 bit: MISO output enable, 1 only during the data phase of a valid read frame.
REQ-010 The module SHALL have port REG_ADR_I, input, 4 bits: local read address.
REQ-011 The module SHALL have port REG_DAT_O, output, 32 bits: combinational read of the register selected by REG_ADR_I.
REQ-012 The module SHALL have port WR_STB, output, 1 bit: one-cycle pulse on each committed SPI write.
REQ-013 The module SHALL have port WR_ADR, output, 4 bits: address of the last committed write.
REQ-014 The module SHALL have port WR_DAT, output, 32 bits: data of the last committed write.
REQ-015 The module SHALL have port FRAME_ERR, output, 1 bit: one-cycle pulse on an aborted or invalid frame.

Function
REQ-016 Frame format SHALL be an 8-bit command followed by 32 data bits, 40 SPI_CLK rising edges in total. Command bit 7: 1=read, 0=write. Bits 6:4 must be 000. Bits 3:0 are the register address.
REQ-017 The synchronized SPI_CLK SHALL be edge-detected in the CLK_I domain; correct operation requires f(SPI_CLK) <= f(CLK_I)/8.
REQ-018 The state machine SHALL be: WAIT (until CS_N high), IDLE, CMD, DATA, DONE (ignore until CS_N high).
REQ-019 State transitions SHALL be:
- IDLE -> CMD on synchronized CS_N falling.
- CMD -> DATA one cycle after the 8th rising edge, when the command is valid.
- DATA -> DONE at the 40th rising edge.
- Any state -> IDLE on CS_N high, except WAIT -> IDLE.
REQ-020 MOSI SHALL be sampled on detected SPI_CLK rising edges; a 6-bit counter SHALL count rising edges within the frame.
REQ-021 Invalid command (bits 6:4 != 000): FRAME_ERR pulse at command decode, go to DONE, no write, MISO_OE stays 0.
REQ-022 Read: at command decode, the addressed register SHALL load a 32-bit shift register, MISO SHALL present bit 31 and MISO_OE SHALL be 1. Each detected falling edge after the 9th..39th rising edge SHALL advance to the next bit. The falling edge after the 8th rising edge SHALL NOT shift.
REQ-023 Write: one cycle after the 40th rising edge, the register SHALL be updated and WR_STB SHALL pulse for 1 cycle, with WR_ADR/WR_DAT valid from that cycle and held until the next commit.
REQ-024 Writes to address 15 SHALL be discarded: no WR_STB, and ID_VALUE is unchanged.
REQ-025 If CS_N rises after 1 to 39 rising edges: no write, FRAME_ERR pulses 1 cycle, state returns to IDLE. CS_N high with 0 edges SHALL produce no error.
REQ-026 Rising edges beyond the 40th SHALL be ignored in DONE: no second write, and MISO holds 0.
REQ-027 REG_DAT_O SHALL reflect a committed write from the cycle after WR_STB, including when REG_ADR_I equals the write address.
REQ-028 Whenever MISO_OE is 0, SPI_MISO SHALL be 0.

Reset
REQ-029 On RST_I high at a CLK_I edge: registers 0-14 = 0, shift registers/counter = 0, WR_STB=0, FRAME_ERR=0, WR_ADR=0, WR_DAT=0, SPI_MISO=0, MISO_OE=0, synchronizers filled with idle levels (CS_N=1, CLK=0, MOSI=0), state = WAIT.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no write and no FRAME_ERR; the module SHALL ignore the bus until CS_N is synchronized high (WAIT state).

Verification
REQ-031 The bench SHALL write 0xDEADBEEF to reg 3 (cmd 0x03) -> WR_STB once, WR_ADR=3, WR_DAT=0xDEADBEEF; with REG_ADR_I=3, REG_DAT_O=0xDEADBEEF the next cycle.
REQ-032 The bench SHALL read reg 3 (cmd 0x83) after REQ-031 -> master captures 0xDEADBEEF, MISO_OE high for exactly the data phase, and no WR_STB.
REQ-033 The bench SHALL read reg 15 (cmd 0x8F), then write 0x12345678 to reg 15 -> reads 0x5A5A0001 both times and no WR_STB.
REQ-034 The bench SHALL raise CS_N after 20 bits of a write to reg 1 -> FRAME_ERR one pulse, reg 1 stays 0; send cmd 0x53 -> FRAME_ERR, no write, MISO=0.
REQ-035 The bench SHALL assert RST_I for 1 cycle after bit 12 of a write to reg 2 with CS_N kept low for 30 more bits -> no write, no FRAME_ERR; the next full frame after CS_N high works normally.
REQ-036 The bench SHALL send 48 clocks in a write frame to reg 4 with 0x0000_00FF -> exactly one WR_STB, reg 4 = 0x000000FF.
